// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM state
// encodings, the access-size decode and the alignment helpers.
package mem_lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Codes 011, 110 and 111 have no RV32I meaning and are treated as words.
    function automatic lsu_size_e lsu_size(input logic [2:0] funct3);
        case (funct3)
            LSU_B, LSU_BU: return SZ_B;
            LSU_H, LSU_HU: return SZ_H;
            default:       return SZ_W;
        endcase
    endfunction

    function automatic logic lsu_unsigned(input logic [2:0] funct3);
        return (funct3 == LSU_BU) || (funct3 == LSU_HU);
    endfunction

    // Byte offset actually used for the access: halfwords drop addr[0],
    // words drop addr[1:0], so a misaligned access lands on its natural slot.
    function automatic logic [1:0] lsu_align_off(input lsu_size_e size,
                                                 input logic [1:0] off);
        case (size)
            SZ_B:    return off;
            SZ_H:    return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input lsu_size_e size,
                                            input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic for the load/store unit.
// Store path: size + byte offset + rs2 -> byte enables and replicated data.
// Load path:  size + byte offset + memory word -> sign/zero-extended result.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_word,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_uns;

    // Store formatting: enables select the lanes, data is replicated to all lanes.
    always_comb begin
        st_be   = 4'b1111;
        st_word = st_data;
        case (lsu_size(st_funct3))
            SZ_B: begin
                st_be   = 4'b0001 << st_offset;
                st_word = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_be   = 4'b0011 << {st_offset[1], 1'b0};
                st_word = {2{st_data[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_word = st_data;
            end
        endcase
    end

    // Load extraction: pick the addressed lane, then extend to 32 bits.
    always_comb begin
        ld_byte = ld_word[7:0];
        ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
        ld_uns  = lsu_unsigned(ld_funct3);
        case (ld_offset)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        case (lsu_size(ld_funct3))
            SZ_B:    ld_data = ld_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = ld_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit for the RV32I memory stage. Accepts one access at a time
// from EX, runs the data-memory handshake and returns load results to WB.
// Optional feature macro: MEM_MISALIGN_EXC_EN (drop misaligned accesses and
// pulse lsu_misalign instead of force-aligning them).
//
// Handshakes:
//   EX -> LSU : an operation is taken on a rising edge where lsu_ready and
//               ex_valid are both high and ex_load or ex_store is set.
//   LSU -> mem: dmem_req and every dmem_* field stay constant until the edge
//               on which dmem_gnt is high; that edge completes the request.
//   mem -> LSU: for a load, the first dmem_rvalid after the grant edge carries
//               the data; rvalid in any other state is ignored.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [4:0]        ex_rd,
    output logic              lsu_ready,
    output logic              lsu_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              lsu_misalign
);

    lsu_state_e state_q, state_d;

    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;

    logic        ex_mem;
    lsu_size_e   ex_size;
    logic [1:0]  ex_off;
    logic        accept;
    logic        rsp;
    logic [3:0]  st_be;
    logic [31:0] st_word;
    logic [31:0] ld_data;

    assign ex_mem  = ex_valid & (ex_load | ex_store);
    assign ex_size = lsu_size(ex_funct3);
    assign ex_off  = lsu_align_off(ex_size, ex_addr[1:0]);

    assign lsu_ready = (state_q == LSU_IDLE);
    assign lsu_stall = ~lsu_ready;

    mem_lsu_align u_align (
        .st_funct3 (ex_funct3),
        .st_offset (ex_off),
        .st_data   (ex_wdata),
        .st_be     (st_be),
        .st_word   (st_word),
        .ld_funct3 (f3_q),
        .ld_offset (off_q),
        .ld_word   (dmem_rdata),
        .ld_data   (ld_data)
    );

`ifdef MEM_MISALIGN_EXC_EN
    logic ex_misal;
    logic drop;
    assign ex_misal = lsu_misaligned(ex_size, ex_addr[1:0]);
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the accept / response strobes that drive the registers.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        rsp     = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
        drop    = 1'b0;
`endif
        case (state_q)
            LSU_IDLE: begin
                if (ex_mem) begin
`ifdef MEM_MISALIGN_EXC_EN
                    if (ex_misal) begin
                        drop = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = LSU_REQ;
                    end
`else
                    accept  = 1'b1;
                    state_d = LSU_REQ;
`endif
                end
            end
            LSU_REQ: begin
                // dmem_we doubles as the "this is a store" flag.
                if (dmem_gnt) begin
                    state_d = dmem_we ? LSU_IDLE : LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (dmem_rvalid) begin
                    rsp     = 1'b1;
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // Request registers: loaded on accept, held through REQ, req cleared on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= ZERO_WORD;
            f3_q       <= LSU_B;
            off_q      <= 2'b00;
            rd_q       <= 5'd0;
        end else if (accept) begin
            // Load has priority when both ex_load and ex_store are set.
            dmem_req   <= 1'b1;
            dmem_we    <= ~ex_load;
            dmem_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
            dmem_be    <= st_be;
            dmem_wdata <= ex_load ? ZERO_WORD : st_word;
            f3_q       <= ex_funct3;
            off_q      <= ex_off;
            rd_q       <= ex_rd;
        end else if ((state_q == LSU_REQ) && dmem_gnt) begin
            dmem_req   <= 1'b0;
        end
    end

    // Writeback registers: one-cycle valid pulse with the extended load data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= ZERO_WORD;
        end else begin
            wb_valid <= rsp;
            if (rsp) begin
                wb_rd   <= rd_q;
                wb_data <= ld_data;
            end
        end
    end

`ifdef MEM_MISALIGN_EXC_EN
    // Misaligned-access pulse, one cycle after the dropped access is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsu_misalign <= 1'b0;
        end else begin
            lsu_misalign <= drop;
        end
    end
`else
    assign lsu_misalign = 1'b0;
`endif

endmodule
